tl_ram_slave: RTL
=================

# tl_ram_slave

TileLink-UL responder backed by a synchronous 64-bit-wide RAM, the memory-side end of the bus driven by the fetch-stage instruction cache and other TileLink masters. It accepts one A-channel request at a time, performs the RAM access, and returns AccessAck/AccessAckData on the D channel. Multi-beat Gets serve cache-line refills at one beat per cycle; Puts are single-beat with byte masks.

## Interface
- `ADDR_BASE`, 64'h0000_0000_8000_0000: byte address of RAM word 0.
- `DEPTH`, 4096: RAM depth in 64-bit words (power of two).
- `MAX_SIZE`, 6: largest accepted `a_size` for Get (2^6 = 64 B = 8 beats).
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `busy`  out  1: high whenever FSM is not IDLE.
- `bus`  tilelink.slave  -: uses `a_valid/a_ready/a_opcode[2:0]/a_size[2:0]/a_source/a_address[63:0]/a_data[63:0]/a_mask[7:0]` and `d_valid/d_ready/d_opcode[2:0]/d_size/d_source/d_data[63:0]/d_error`.

## Operation
- Opcodes: Get(4) -> AccessAckData(1); PutFullData(0), PutPartialData(1) -> AccessAck(0). Any other opcode -> AccessAck(0), `d_error`=1, no RAM access.
- `d_size`, `d_source` = captured `a_size`, `a_source` for every beat of the response.
- Word index = (`a_address` - `ADDR_BASE`) >> 3.
- Error (`d_error`=1, `d_data`=0, no write) when: address outside [`ADDR_BASE`, `ADDR_BASE`+8*`DEPTH`); address not aligned to 2^`a_size`; Get with `a_size` > `MAX_SIZE`; Put with `a_size` > 3. Errored Get still returns the full beat count of its size (if size > `MAX_SIZE`: 1 beat).
- Get beats = max(1, 2^`a_size` / 8); beat i reads index base+i. Sub-word Gets (size<3) return the whole containing word; master selects lanes.
- Put: bytes with `a_mask[k]`=1 written from `a_data[8k+7:8k]`; PutFull treated identically (mask honored).
- FSM: IDLE -> (accept Get) RD -> (last beat handshaken) IDLE; IDLE -> (accept Put/other) ACK -> (d handshake) IDLE.
- `a_ready` = 1 only in IDLE and not in reset; one outstanding request.
- Beat counter 3 bits, counts 0..beats-1; `d_valid` drops the cycle after last-beat handshake.

## Timing
- Reset (cycle after `rst` high sampled): FSM IDLE, `d_valid`=0, `d_error`=0, `d_data`=0, `busy`=0, beat counter 0; `a_ready`=0 while `rst` high, 1 the first cycle after.
- Accept at cycle T (`a_valid`&`a_ready`). Get: RAM read issued at T, `d_valid` with beat 0 at T+1. Put: RAM write at T, AccessAck `d_valid` at T+1. Errored request: response at T+1.
- Burst: handshake of beat i at cycle C issues read of beat i+1 at C; beat i+1 valid at C+1. `d_ready` held high -> 8-beat Get completes in cycles T+1..T+8, `a_ready` back at T+9.
- Backpressure: while `d_valid` & !`d_ready`, all `d_*` held stable (RAM address/enable held); no beat dropped or repeated.
- Earliest next accept: cycle after final D handshake (no same-cycle A accept on last D beat).
- `rst` mid-burst or mid-ack: response abandoned, `d_valid`=0 next cycle, RAM contents retained, no partial write.
- Address arithmetic in 64 bits; index taken modulo nothing — out-of-range detected before truncation.

## Test plan
- Put 64'hDEAD_BEEF_0123_4567 mask 8'hFF at 0x8000_0010, source 3 -> AccessAck at T+1, d_source=3, d_error=0; Get size 3 same addr -> AccessAckData 64'hDEAD_BEEF_0123_4567 at T+1.
- PutPartial mask 8'h0F data 64'hFFFF_FFFF_AAAA_AAAA over that word -> Get returns 64'hDEAD_BEEF_AAAA_AAAA.
- Preload words 0..7 with index values; Get size 6 at 0x8000_0000, d_ready=1 -> 8 beats data 0..7 in consecutive cycles T+1..T+8, busy 1 during, a_ready 1 at T+9.
- Same burst with d_ready toggled 1,0,0,1,... -> all 8 beats in order, each stable while stalled, no duplicates.
- Get at 0x8000_8000 (DEPTH=4096), Get size 3 at 0x8000_0004, Put size 4, opcode 5 -> each d_error=1, d_data=0, RAM unchanged (verify by readback).
- Assert rst during beat 3 of a burst -> d_valid=0 next cycle, busy=0, a_ready=1 after rst release; fresh Get returns correct data.

Source files
------------

// File: rtl/tl_ram_slave_if.sv
// TileLink-UL A/D channel bundle; the slave modport is the memory-side view.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [63:0] a_data;
    logic [7:0]  a_mask;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic [63:0] d_data;
    logic        d_error;

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_data, a_mask, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
    );
endinterface

// File: rtl/tl_ram_slave.sv
// TileLink-UL RAM responder: one request in flight, first D beat one cycle after accept.
// Bursts stream one beat per cycle; a stalled D beat holds all d_* and the RAM read port.
module tl_ram_slave #(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          MAX_SIZE  = 6
) (
    input  logic   clk,
    input  logic   rst,
    output logic   busy,
    tilelink.slave bus
);
    localparam int          IDX_W  = $clog2(DEPTH);
    localparam logic [2:0]  MAX_SZ = 3'(MAX_SIZE);
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

    state_t           state_q, state_d;
    logic [2:0]       beat_q, beat_d;
    logic [2:0]       last_q, last_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic [2:0]       dop_q, dop_d;
    logic [2:0]       dsz_q, dsz_d;
    logic [3:0]       src_q, src_d;
    logic             err_q, err_d;
    logic [63:0]      ram_rdata_q;
    logic [63:0]      mem [DEPTH];

    logic [63:0]      off;
    logic [63:0]      align_m;
    logic             is_get, is_put, req_err, acc, rd_en, wr_en;
    logic [IDX_W-1:0] idx, rd_addr;

    // Range check is done on the full 64-bit offset before it is cut down to an index.
    always_comb begin
        off     = bus.a_address - ADDR_BASE;
        align_m = (64'd1 << bus.a_size) - 64'd1;
        is_get  = bus.a_opcode == 3'd4;
        is_put  = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
        req_err = (bus.a_address < ADDR_BASE) || (off >= SPAN)
               || ((bus.a_address & align_m) != 64'd0)
               || (is_get && (bus.a_size > MAX_SZ))
               || (is_put && (bus.a_size > 3'd3))
               || !(is_get || is_put);
        idx     = off[IDX_W+2:3];
    end

    assign bus.a_ready = (state_q == IDLE) && !rst;
    assign acc         = bus.a_valid && bus.a_ready;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        last_d  = last_q;
        base_d  = base_q;
        dop_d   = dop_q;
        dsz_d   = dsz_q;
        src_d   = src_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        rd_addr = idx;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    beat_d = 3'd0;
                    last_d = 3'd0;
                    base_d = idx;
                    dop_d  = is_get ? 3'd1 : 3'd0;
                    dsz_d  = bus.a_size;
                    src_d  = bus.a_source;
                    err_d  = req_err;
                    if (is_get) begin
                        state_d = RD;
                        rd_en   = !req_err;
                        // Oversized Gets answer with a single errored beat.
                        if ((bus.a_size > 3'd3) && (bus.a_size <= MAX_SZ))
                            last_d = 3'((4'd1 << (bus.a_size - 3'd3)) - 4'd1);
                    end else begin
                        state_d = ACK;
                        wr_en   = !req_err;
                    end
                end
            end
            RD: begin
                if (bus.d_ready) begin
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                        beat_d  = 3'd0;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        rd_en   = !err_q;
                        rd_addr = base_q + IDX_W'(beat_q) + IDX_W'(1);
                    end
                end
            end
            ACK: begin
                if (bus.d_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            last_q  <= 3'd0;
            base_q  <= '0;
            dop_q   <= 3'd0;
            dsz_q   <= 3'd0;
            src_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            base_q  <= base_d;
            dop_q   <= dop_d;
            dsz_q   <= dsz_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    // RAM keeps its contents through reset; the read register only moves on a new read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.a_mask[k])
                    mem[idx][8*k +: 8] <= bus.a_data[8*k +: 8];
            end
        end
        if (rd_en)
            ram_rdata_q <= mem[rd_addr];
    end

    assign busy         = state_q != IDLE;
    assign bus.d_valid  = state_q != IDLE;
    assign bus.d_opcode = dop_q;
    assign bus.d_size   = dsz_q;
    assign bus.d_source = src_q;
    assign bus.d_error  = err_q;
    assign bus.d_data   = ((state_q == RD) && !err_q) ? ram_rdata_q : 64'd0;
endmodule
